mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 64-bit memory port between the instruction-fetch path (icache miss/refill) and the data path (dcache / load-store unit).
- Data requests win by default. A starvation counter guarantees that fetch requests make forward progress.
- A tag-owner table records which requester owns each outstanding load, so returned data is routed back to that requester.
- Sits between the fetch/dcache controllers and the tagged memory model.

Parameters:
- NUM_TAGS, 16, number of memory tags. Tag 0 means "none"; tags 1..NUM_TAGS-1 are usable.
- STARVE_LIMIT, 4, consecutive denied cycles of a pending fetch request before fetch is forced to win.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request valid; held until granted
- if_addr_i  in  `XLEN  fetch address, 8-byte aligned
- if_grant_o  out  1  fetch request accepted this cycle
- if_rsp_valid_o  out  1  fetch data returned this cycle
- if_rsp_data_o  out  64  fetch return data
- d_req_i  in  1  data request valid; held until granted
- d_cmd_i  in  2  1=LOAD, 2=STORE (0 is illegal while d_req_i=1)
- d_addr_i  in  `XLEN  data address
- d_wdata_i  in  64  store data
- d_grant_o  out  1  data request accepted this cycle
- d_rsp_valid_o  out  1  load data returned this cycle
- d_rsp_data_o  out  64  load return data
- proc2mem_command_o  out  2  0=NONE, 1=LOAD, 2=STORE
- proc2mem_addr_o  out  `XLEN  memory address
- proc2mem_data_o  out  64  memory store data
- mem2proc_response_i  in  $clog2(NUM_TAGS)  nonzero = command accepted, carrying the assigned tag
- mem2proc_tag_i  in  $clog2(NUM_TAGS)  nonzero = data for this tag is valid
- mem2proc_data_i  in  64  returned data
- spurious_tag_o  out  1  pulse: returned tag had no owner

Behaviour:
- Selection (combinational, same cycle):
  - Data is selected if d_req_i=1, unless the fetch-force flag is set and if_req_i=1.
  - Otherwise fetch is selected if if_req_i=1.
  - Otherwise the command is NONE.
- Command outputs (combinational):
  - The command, address and data of the selected requester drive proc2mem_*.
  - Fetch always issues LOAD.
  - Unselected outputs drive 0.
- Grant:
  - Grant is combinational: x_grant_o = selected_x && mem2proc_response_i != 0.
  - A requester must hold its request, address and data stable until its grant.
  - If response is 0, no grant is given and the same selection logic re-evaluates next cycle.
- Starvation counter (registered):
  - Increments on a cycle where if_req_i=1 and if_grant_o=0; saturates at STARVE_LIMIT.
  - Clears on if_grant_o=1 or on if_req_i=0.
  - The fetch-force flag is (counter == STARVE_LIMIT).
- Tag-owner table:
  - One valid bit plus one owner bit (0=fetch, 1=data) per tag, registered.
  - On a granted LOAD, entry[response] is set: valid=1, owner=requester.
  - A granted STORE allocates no entry.
- Response routing:
  - Trigger: mem2proc_tag_i != 0 and entry[tag] is valid.
  - Action, same cycle: pulse the owner's rsp_valid_o for one cycle with rsp_data = mem2proc_data_i, and clear the entry at the clock edge.
- Unknown tag: mem2proc_tag_i != 0 with the entry invalid → no rsp_valid; spurious_tag_o=1 for that cycle.
- Simultaneous allocate and return of the same tag in one cycle: the allocation wins (entry stays valid with the new owner). The return is still routed using the old owner.
- Both response valids may never be 1 in the same cycle; only one tag returns per cycle.
- Reset values:
  - All entries invalid, counter 0.
  - All outputs 0; proc2mem_command_o = NONE.
- Reset asserted mid-operation: the table is cleared immediately. Post-reset returns of old tags are dropped with spurious_tag_o=1.
- Latency: request to grant is 0 cycles when memory accepts. Data returns in the cycle mem2proc_tag_i matches, with no added register stage.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, the block adds 32-bit saturating counters that clear on reset:
  - if_grant_cnt_o
  - d_grant_cnt_o
  - stall_cnt_o: counts cycles with any request pending and no grant
  - starve_force_cnt_o: counts cycles where the fetch-force flag is set
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Fetch-only request: if_req=1, if_addr=0x40, response=3 → if_grant=1, command=LOAD, addr=0x40. Later tag=3, data=0xDEAD → if_rsp_valid=1, data=0xDEAD, entry 3 cleared.
- Both requesting, response=5 every cycle → data is granted 4 consecutive cycles; the 5th grant goes to fetch; the counter then returns to 0.
- Store granted with response=7, then tag=7 returned → spurious_tag_o=1 and no rsp_valid (stores allocate no entry).
- Memory busy: response=0 for 3 cycles with d_req held → no grant and outputs stable; response=2 on cycle 4 → d_grant=1.
- Same-cycle allocate/return: tag 4 owned by data returns while fetch is granted with response=4 → d_rsp_valid=1; entry 4 is now owned by fetch; a later tag=4 return → if_rsp_valid=1.
- Reset mid-flight: tags 1 and 2 outstanding, reset pulsed low, then tag=1 returned → spurious_tag_o=1 and no rsp_valid.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one tagged 64-bit memory port between instruction fetch and the data path.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter #(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        if_req_i,
  input  logic [`XLEN-1:0]            if_addr_i,
  output logic                        if_grant_o,
  output logic                        if_rsp_valid_o,
  output logic [DATA_W-1:0]           if_rsp_data_o,
  input  logic                        d_req_i,
  input  logic [1:0]                  d_cmd_i,
  input  logic [`XLEN-1:0]            d_addr_i,
  input  logic [DATA_W-1:0]           d_wdata_i,
  output logic                        d_grant_o,
  output logic                        d_rsp_valid_o,
  output logic [DATA_W-1:0]           d_rsp_data_o,
  output logic [1:0]                  proc2mem_command_o,
  output logic [`XLEN-1:0]            proc2mem_addr_o,
  output logic [DATA_W-1:0]           proc2mem_data_o,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_response_i,
  input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_tag_i,
  input  logic [DATA_W-1:0]           mem2proc_data_i,
  output logic                        spurious_tag_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]                 if_grant_cnt_o,
  output logic [31:0]                 d_grant_cnt_o,
  output logic [31:0]                 stall_cnt_o,
  output logic [31:0]                 starve_force_cnt_o
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;

  logic [CNT_W-1:0]    starve_cnt;
  logic                force_if;
  logic                sel_d;
  logic                sel_if;
  logic                accept;
  logic                alloc;
  logic                ret_hit;
  logic                ret_owner;
  logic [NUM_TAGS-1:0] tag_valid;
  logic [NUM_TAGS-1:0] tag_owner;

  function automatic logic [CNT_W-1:0] starve_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(STARVE_LIMIT)) ? c : c + 1'b1;
  endfunction

  // Selection and grant are purely combinational so an accepted request costs no cycles
  always_comb begin
    force_if   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    sel_d      = d_req_i && !(force_if && if_req_i);
    sel_if     = if_req_i && !sel_d;
    accept     = (mem2proc_response_i != '0);
    if_grant_o = sel_if && accept;
    d_grant_o  = sel_d && accept;
  end

  always_comb begin
    proc2mem_command_o = CMD_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    if (sel_d) begin
      proc2mem_command_o = d_cmd_i;
      proc2mem_addr_o    = d_addr_i;
      proc2mem_data_o    = d_wdata_i;
    end else if (sel_if) begin
      proc2mem_command_o = CMD_LOAD;
      proc2mem_addr_o    = if_addr_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!if_req_i || if_grant_o) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_sat_inc(starve_cnt);
    end
  end

  // Returns are routed with the owner read before this edge's allocation takes effect
  always_comb begin
    alloc          = (if_grant_o || d_grant_o) && (proc2mem_command_o == CMD_LOAD);
    ret_hit        = (mem2proc_tag_i != '0) && tag_valid[mem2proc_tag_i];
    ret_owner      = tag_owner[mem2proc_tag_i];
    spurious_tag_o = (mem2proc_tag_i != '0) && !tag_valid[mem2proc_tag_i];
    if_rsp_valid_o = ret_hit && !ret_owner;
    d_rsp_valid_o  = ret_hit && ret_owner;
    if_rsp_data_o  = if_rsp_valid_o ? mem2proc_data_i : '0;
    d_rsp_data_o   = d_rsp_valid_o ? mem2proc_data_i : '0;
  end

  // Allocation is written last so it overrides a same-tag clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      if (ret_hit) begin
        tag_valid[mem2proc_tag_i] <= 1'b0;
      end
      if (alloc) begin
        tag_valid[mem2proc_response_i] <= 1'b1;
        tag_owner[mem2proc_response_i] <= d_grant_o;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  function automatic logic [31:0] perf_sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_grant_cnt_o     <= '0;
      d_grant_cnt_o      <= '0;
      stall_cnt_o        <= '0;
      starve_force_cnt_o <= '0;
    end else begin
      if_grant_cnt_o     <= perf_sat_inc(if_grant_cnt_o, if_grant_o);
      d_grant_cnt_o      <= perf_sat_inc(d_grant_cnt_o, d_grant_o);
      stall_cnt_o        <= perf_sat_inc(stall_cnt_o,
                              (if_req_i || d_req_i) && !(if_grant_o || d_grant_o));
      starve_force_cnt_o <= perf_sat_inc(starve_force_cnt_o, force_if);
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Vector table plus a return-data scoreboard for mem_bus_arbiter.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arbiter;

  typedef struct {
    logic             rst;
    logic             if_req;
    logic [`XLEN-1:0] if_addr;
    logic             d_req;
    logic [1:0]       d_cmd;
    logic [`XLEN-1:0] d_addr;
    logic [63:0]      d_wdata;
    logic [3:0]       resp;
    logic [3:0]       tag;
    logic [63:0]      rdata;
    logic             e_ifg;
    logic             e_dg;
    logic [1:0]       e_cmd;
    logic [`XLEN-1:0] e_addr;
    logic [63:0]      e_data;
    logic             e_ifv;
    logic             e_dv;
    logic             e_sp;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [63:0] data;
  } rsp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             if_req = 1'b0;
  logic [`XLEN-1:0] if_addr = '0;
  logic             if_grant;
  logic             if_rsp_valid;
  logic [63:0]      if_rsp_data;
  logic             d_req = 1'b0;
  logic [1:0]       d_cmd = '0;
  logic [`XLEN-1:0] d_addr = '0;
  logic [63:0]      d_wdata = '0;
  logic             d_grant;
  logic             d_rsp_valid;
  logic [63:0]      d_rsp_data;
  logic [1:0]       p_cmd;
  logic [`XLEN-1:0] p_addr;
  logic [63:0]      p_data;
  logic [3:0]       mem_resp = '0;
  logic [3:0]       mem_tag = '0;
  logic [63:0]      mem_data = '0;
  logic             spurious;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]      if_gcnt, d_gcnt, stall_cnt, force_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  rsp_t sb[$];

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .if_req_i            (if_req),
    .if_addr_i           (if_addr),
    .if_grant_o          (if_grant),
    .if_rsp_valid_o      (if_rsp_valid),
    .if_rsp_data_o       (if_rsp_data),
    .d_req_i             (d_req),
    .d_cmd_i             (d_cmd),
    .d_addr_i            (d_addr),
    .d_wdata_i           (d_wdata),
    .d_grant_o           (d_grant),
    .d_rsp_valid_o       (d_rsp_valid),
    .d_rsp_data_o        (d_rsp_data),
    .proc2mem_command_o  (p_cmd),
    .proc2mem_addr_o     (p_addr),
    .proc2mem_data_o     (p_data),
    .mem2proc_response_i (mem_resp),
    .mem2proc_tag_i      (mem_tag),
    .mem2proc_data_i     (mem_data),
    .spurious_tag_o      (spurious)
`ifdef MEM_ARB_PERF_EN
    ,
    .if_grant_cnt_o      (if_gcnt),
    .d_grant_cnt_o       (d_gcnt),
    .stall_cnt_o         (stall_cnt),
    .starve_force_cnt_o  (force_cnt)
`endif
  );

  function automatic vec_t mk(
    input logic rst, input logic ifr, input logic [`XLEN-1:0] ifa,
    input logic dr, input logic [1:0] dc, input logic [`XLEN-1:0] da, input logic [63:0] dw,
    input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] rd,
    input logic eig, input logic edg, input logic [1:0] ec, input logic [`XLEN-1:0] ea,
    input logic [63:0] ed, input logic eiv, input logic edv, input logic esp);
    vec_t v;
    v.rst = rst; v.if_req = ifr; v.if_addr = ifa; v.d_req = dr; v.d_cmd = dc;
    v.d_addr = da; v.d_wdata = dw; v.resp = rsp; v.tag = tg; v.rdata = rd;
    v.e_ifg = eig; v.e_dg = edg; v.e_cmd = ec; v.e_addr = ea; v.e_data = ed;
    v.e_ifv = eiv; v.e_dv = edv; v.e_sp = esp;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_cmd = '0; d_addr = '0; d_wdata = '0;
    mem_resp = '0; mem_tag = '0; mem_data = '0;
  endtask

  task automatic req_until_grant(input logic is_d, input logic [`XLEN-1:0] addr,
                                 input logic [3:0] tag, input int busy);
    int               cyc;
    logic             got;
    logic [`XLEN-1:0] seen;
    cyc = 0; got = 1'b0; seen = '0;
    if_req = !is_d; if_addr = is_d ? '0 : addr;
    d_req = is_d; d_cmd = is_d ? 2'd1 : 2'd0; d_addr = is_d ? addr : '0; d_wdata = '0;
    while (!got && cyc < 16) begin
      mem_resp = (cyc >= busy) ? tag : 4'd0;
      @(negedge clk);
      got = is_d ? d_grant : if_grant;
      seen = p_addr;
      cyc++;
      @(posedge clk); #1;
    end
    chk("grant_cycle", tag, 128'({got, 32'(cyc)}), 128'({1'b1, 32'(busy + 1)}));
    chk("grant_addr", tag, 128'(seen), 128'(addr));
    idle_inputs();
  endtask

  task automatic ret(input logic [3:0] tag, input logic [63:0] data, input logic owner);
    rsp_t r;
    rsp_t g;
    mem_tag = tag; mem_data = data;
    r.owner = owner; r.data = data;
    sb.push_back(r);
    @(negedge clk);
    if (if_rsp_valid || d_rsp_valid) begin
      g = sb.pop_front();
      chk("sb_rsp", tag,
          128'({if_rsp_valid, d_rsp_valid, d_rsp_valid ? d_rsp_data : if_rsp_data}),
          128'({!g.owner, g.owner, g.data}));
    end else begin
      checks++;
      errors++;
      $display("FAIL sb_rsp #%0d: got no rsp_valid expected owner %0d", tag, owner);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t e;
    // rst ifr ifa  dr dc da  dw  rsp tag rdata | ifg dg cmd addr data ifv dv sp
    vecs.push_back(mk(1, 0, 0,    0, 0, 0,     0,      0, 0, 0,      0, 0, 0, 0,     0,      0, 0, 0));
    vecs.push_back(mk(0, 1, 'h40, 0, 0, 0,     0,      3, 0, 0,      1, 0, 1, 'h40,  0,      0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 3, 'hDEAD, 0, 0, 0, 0,     0,      1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 3, 'h1234, 0, 0, 0, 0,     0,      0, 0, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 'h40, 1, 1, 'h100, 'h11, 5, 0, 0,      0, 1, 1, 'h100, 'h11,   0, 0, 0));
    vecs.push_back(mk(0, 1, 'h40, 1, 1, 'h100, 'h11,   5, 0, 0,      1, 0, 1, 'h40,  0,      0, 0, 0));
    vecs.push_back(mk(0, 1, 'h40, 1, 1, 'h100, 'h11,   5, 0, 0,      0, 1, 1, 'h100, 'h11,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 5, 'h55,   0, 0, 0, 0,     0,      0, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0,  1, 2, 'h200, 'hCAFE, 0, 0, 0,      0, 0, 2, 'h200, 'hCAFE, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    1, 2, 'h200, 'hCAFE, 2, 0, 0,      0, 1, 2, 'h200, 'hCAFE, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    1, 2, 'h300, 'hBEEF, 7, 0, 0,      0, 1, 2, 'h300, 'hBEEF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 7, 'h77,   0, 0, 0, 0,     0,      0, 0, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 'h40, 1, 1, 'h100, 'h11, 0, 0, 0,      0, 0, 1, 'h100, 'h11,   0, 0, 0));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(0, 1, 'h40, 1, 1, 'h100, 'h11, 0, 0, 0,      0, 0, 1, 'h40,  0,      0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    1, 1, 'h100, 'h11,   0, 0, 0,      0, 0, 1, 'h100, 'h11,   0, 0, 0));
    vecs.push_back(mk(0, 1, 'h40, 1, 1, 'h100, 'h11,   0, 0, 0,      0, 0, 1, 'h100, 'h11,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    1, 1, 'h400, 0,      4, 0, 0,      0, 1, 1, 'h400, 0,      0, 0, 0));
    vecs.push_back(mk(0, 1, 'h80, 0, 0, 0,     0,      4, 4, 'h4444, 1, 0, 1, 'h80,  0,      0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 4, 'h8888, 0, 0, 0, 0,     0,      1, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 4, 'h1,    0, 0, 0, 0,     0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    1, 1, 'h500, 0,      1, 0, 0,      0, 1, 1, 'h500, 0,      0, 0, 0));
    vecs.push_back(mk(0, 1, 'h88, 0, 0, 0,     0,      2, 0, 0,      1, 0, 1, 'h88,  0,      0, 0, 0));
    vecs.push_back(mk(1, 0, 0,    0, 0, 0,     0,      0, 0, 0,      0, 0, 0, 0,     0,      0, 0, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 1, 'h71,   0, 0, 0, 0,     0,      0, 0, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,     0,      0, 2, 'h72,   0, 0, 0, 0,     0,      0, 0, 1));

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      reset = v.rst ? 1'b0 : 1'b1;
      if_req = v.if_req; if_addr = v.if_addr;
      d_req = v.d_req; d_cmd = v.d_cmd; d_addr = v.d_addr; d_wdata = v.d_wdata;
      mem_resp = v.resp; mem_tag = v.tag; mem_data = v.rdata;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      chk("grant", i, 128'({if_grant, d_grant}), 128'({e.e_ifg, e.e_dg}));
      chk("command", i, 128'({p_cmd, p_addr, p_data}), 128'({e.e_cmd, e.e_addr, e.e_data}));
      chk("response", i, 128'({if_rsp_valid, d_rsp_valid, spurious}),
          128'({e.e_ifv, e.e_dv, e.e_sp}));
      if (e.e_ifv) chk("if_rsp_data", i, 128'(if_rsp_data), 128'(e.rdata));
      if (e.e_dv)  chk("d_rsp_data", i, 128'(d_rsp_data), 128'(e.rdata));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    idle_inputs();

    req_until_grant(1'b0, 'h900, 4'd9, 2);
    req_until_grant(1'b1, 'hA00, 4'd10, 1);
    req_until_grant(1'b0, 'h908, 4'd11, 0);
    ret(4'd10, 64'hA0A0_0000_0000_A0A0, 1'b1);
    ret(4'd9,  64'h9090_1111_2222_9090, 1'b0);
    ret(4'd11, 64'h1111_3333_4444_1111, 1'b0);
    chk("sb_empty", 0, 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
